// File: rtl/lcd_write_sequencer.sv
// HD44780-style write-only bus sequencer: one byte per request with timed
// setup, E pulse, hold and execution wait phases.
module lcd_write_sequencer #(
  parameter int unsigned CLK_PER_US = 50,
  parameter int unsigned T_SETUP_US = 1,
  parameter int unsigned T_PULSE_US = 1,
  parameter int unsigned T_HOLD_US  = 1,
  parameter int unsigned T_EXEC_US  = 40,
  parameter int unsigned T_LONG_US  = 1640
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       ready,
  output logic       done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, EXEC} state_t;

  localparam logic [7:0]  PRE_MAX  = 8'(CLK_PER_US - 1);
  localparam logic [10:0] SETUP_M1 = 11'(T_SETUP_US - 1);
  localparam logic [10:0] PULSE_M1 = 11'(T_PULSE_US - 1);
  localparam logic [10:0] HOLD_M1  = 11'(T_HOLD_US - 1);
  localparam logic [10:0] EXEC_M1  = 11'(T_EXEC_US - 1);
  localparam logic [10:0] LONG_M1  = 11'(T_LONG_US - 1);

  state_t      state, state_nxt;
  logic [7:0]  pre;
  logic [10:0] us_cnt;
  logic [10:0] dur_m1;
  logic        long_wait;
  logic        tick;
  logic        last;
  logic        accept;

  assign tick   = (pre == PRE_MAX);
  assign accept = wr_valid && (state == IDLE);
  assign ready  = (state == IDLE);
  assign lcd_e  = (state == PULSE);
  assign lcd_rw = 1'b0;

  always_comb begin
    dur_m1 = '0;
    case (state)
      SETUP:   dur_m1 = SETUP_M1;
      PULSE:   dur_m1 = PULSE_M1;
      HOLD:    dur_m1 = HOLD_M1;
      EXEC:    dur_m1 = long_wait ? LONG_M1 : EXEC_M1;
      default: dur_m1 = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    last      = tick && (us_cnt == dur_m1);
    case (state)
      IDLE:  if (wr_valid) state_nxt = SETUP;
      SETUP: if (last) state_nxt = PULSE;
      PULSE: if (last) state_nxt = HOLD;
      HOLD:  if (last) state_nxt = EXEC;
      EXEC: begin
        if (last) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pre       <= '0;
      us_cnt    <= '0;
      lcd_rs    <= 1'b0;
      lcd_data  <= '0;
      long_wait <= 1'b0;
    end else begin
      state <= state_nxt;
      // Every transition is a state entry, so both counters restart there.
      if (state_nxt != state) begin
        pre    <= '0;
        us_cnt <= '0;
      end else if (state != IDLE) begin
        if (tick) begin
          pre    <= '0;
          us_cnt <= us_cnt + 11'd1;
        end else begin
          pre <= pre + 8'd1;
        end
      end
      if (accept) begin
        lcd_rs    <= wr_rs;
        lcd_data  <= wr_data;
        long_wait <= !wr_rs && (wr_data[7:2] == 6'd0);
      end
    end
  end

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Scoreboard bench for lcd_write_sequencer at CLK_PER_US=4: stimulus pushes
// expected writes, a negedge monitor pops and checks them on each done.
module tb_lcd_write_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_rs = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       ready, done, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_data;

  lcd_write_sequencer #(
    .CLK_PER_US(4),
    .T_SETUP_US(1),
    .T_PULSE_US(1),
    .T_HOLD_US(1),
    .T_EXEC_US(40),
    .T_LONG_US(1640)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_valid(wr_valid),
    .wr_rs(wr_rs),
    .wr_data(wr_data),
    .ready(ready),
    .done(done),
    .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw),
    .lcd_e(lcd_e),
    .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         lat;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int prev_acc = 0;
  int n_acc = 0;
  int n_done = 0;
  int e_start = 0;
  int e_len = 0;
  logic e_prev = 1'b0;
  logic chk_ready = 1'b0;

  localparam int LAT_NORM = 172;
  localparam int LAT_LONG = 6572;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change only at posedge+#1, so at negedge they show what the next edge samples.
  always @(negedge clk) begin
    exp_t e;
    if (chk_ready) begin
      check("ready_after_done", int'(ready), 1);
      chk_ready = 1'b0;
    end
    if (lcd_e && !e_prev) e_start = cyc - acc_cyc + 1;
    if (lcd_e) e_len++;
    e_prev = lcd_e;
    if (done) begin
      n_done++;
      chk_ready = 1'b1;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("done_latency", cyc - acc_cyc + 1, e.lat);
        check("lcd_data", int'(lcd_data), int'(e.data));
        check("lcd_rs", int'(lcd_rs), int'(e.rs));
        check("lcd_rw", int'(lcd_rw), 0);
        check("e_start", e_start, 5);
        check("e_len", e_len, 4);
      end
    end
    if (wr_valid && ready && !rst) begin
      prev_acc = acc_cyc;
      acc_cyc = cyc + 1;
      n_acc++;
      e_len = 0;
      e_start = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int base);
    int budget;
    budget = 8000;
    while (n_done == base && budget > 0) begin
      tick(1);
      budget--;
    end
    if (budget == 0) check("done_timeout", 0, 1);
  endtask

  task automatic do_write(input logic rs, input logic [7:0] data, input int lat);
    exp_t e;
    int base_d;
    e.rs = rs;
    e.data = data;
    e.lat = lat;
    exp_q.push_back(e);
    base_d = n_done;
    wr_rs = rs;
    wr_data = data;
    wr_valid = 1'b1;
    tick(1);
    wr_valid = 1'b0;
    wait_done(base_d);
    tick(2);
  endtask

  initial begin
    int base_a, base_d, budget;
    tick(3);
    check("rst_ready", int'(ready), 1);
    check("rst_done", int'(done), 0);
    check("rst_e", int'(lcd_e), 0);
    check("rst_rw", int'(lcd_rw), 0);
    check("rst_rs", int'(lcd_rs), 0);
    check("rst_data", int'(lcd_data), 0);
    rst = 1'b0;
    tick(2);

    do_write(1'b1, 8'h41, LAT_NORM);
    do_write(1'b0, 8'h01, LAT_LONG);
    do_write(1'b0, 8'h03, LAT_LONG);
    do_write(1'b0, 8'h04, LAT_NORM);
    do_write(1'b1, 8'h01, LAT_NORM);
    check("idle_data_kept", int'(lcd_data), 8'h01);
    check("idle_rs_kept", int'(lcd_rs), 1);

    // Request presented while busy must be dropped.
    base_a = n_acc;
    base_d = n_done;
    exp_q.push_back('{rs: 1'b1, data: 8'h55, lat: LAT_NORM});
    wr_rs = 1'b1; wr_data = 8'h55; wr_valid = 1'b1;
    tick(1);
    wr_valid = 1'b0;
    tick(20);
    wr_rs = 1'b0; wr_data = 8'hAA; wr_valid = 1'b1;
    tick(1);
    wr_valid = 1'b0;
    check("busy_data_held", int'(lcd_data), 8'h55);
    wait_done(base_d);
    tick(200);
    check("busy_acc_count", n_acc - base_a, 1);
    check("busy_done_count", n_done - base_d, 1);

    // Reset in PULSE aborts the write.
    base_d = n_done;
    wr_rs = 1'b1; wr_data = 8'h66; wr_valid = 1'b1;
    tick(1);
    wr_valid = 1'b0;
    budget = 50;
    while (!lcd_e && budget > 0) begin
      tick(1);
      budget--;
    end
    check("pulse_reached", int'(lcd_e), 1);
    rst = 1'b1;
    tick(1);
    check("abort_e", int'(lcd_e), 0);
    check("abort_ready", int'(ready), 1);
    check("abort_data", int'(lcd_data), 0);
    rst = 1'b0;
    tick(200);
    check("abort_no_done", n_done - base_d, 0);

    // Reset wins over a simultaneous request.
    rst = 1'b1; wr_rs = 1'b1; wr_data = 8'h77; wr_valid = 1'b1;
    tick(1);
    rst = 1'b0; wr_valid = 1'b0;
    tick(1);
    check("rst_prio_data", int'(lcd_data), 0);
    check("rst_prio_ready", int'(ready), 1);

    // Back-to-back with wr_valid held high.
    base_a = n_acc;
    base_d = n_done;
    exp_q.push_back('{rs: 1'b1, data: 8'h31, lat: LAT_NORM});
    exp_q.push_back('{rs: 1'b1, data: 8'h32, lat: LAT_NORM});
    wr_rs = 1'b1; wr_data = 8'h31; wr_valid = 1'b1;
    budget = 500;
    while (n_acc < base_a + 1 && budget > 0) begin tick(1); budget--; end
    wr_data = 8'h32;
    while (n_acc < base_a + 2 && budget > 0) begin tick(1); budget--; end
    wr_valid = 1'b0;
    check("b2b_accepts", n_acc - base_a, 2);
    check("b2b_spacing", acc_cyc - prev_acc, 173);
    wait_done(base_d + 1);
    tick(5);
    check("b2b_dones", n_done - base_d, 2);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
